// File: rtl/lpgbt_fifo_emulator.sv
// lpGBT link emulator: drains a source FIFO into a sink FIFO (plain or inverted) or emits a counter pattern.
// Optional build macro LPGBT_EMU_STATS_EN enables the saturating word_cnt statistics counter.
module lpgbt_fifo_emulator #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] DO,
  input  logic              EMPTY,
  input  logic              RDBUSY,
  input  logic              FULL,
  input  logic              WRBUSY,
  output logic              RDEN,
  output logic [DATA_W-1:0] DI,
  output logic              WREN,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [1:0]        MODE_OFF  = 2'd0;
  localparam logic [1:0]        MODE_LOOP = 2'd1;
  localparam logic [1:0]        MODE_CNT  = 2'd2;
  localparam logic [1:0]        MODE_INV  = 2'd3;
  localparam logic [DATA_W-1:0] PAT_ONE   = 1;

  state_t            state_reg, state_next;
  logic [1:0]        mode_reg;
  logic              rd_pend_reg;
  logic              hold_v_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] pat_reg;
  logic [DATA_W-1:0] di_reg;
  logic              wren_reg;
  logic              err_reg;
  logic              loop_mode;
  logic              sink_ready;
  logic [DATA_W-1:0] rx_word;

  assign loop_mode  = (mode_reg == MODE_LOOP) || (mode_reg == MODE_INV);
  assign sink_ready = !FULL && !WRBUSY;
  assign rx_word    = (mode_reg == MODE_INV) ? ~DO : DO;

  // A new read is only issued when the returning word is guaranteed a landing spot
  // (sink ready now, hold register free), so at most one word is in flight plus one held.
  always_comb begin
    state_next = state_reg;
    RDEN       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        RDEN = loop_mode && !EMPTY && !RDBUSY && sink_ready && !hold_v_reg;
        if (!enable) state_next = DRAIN;
      end
      DRAIN: begin
        if (!rd_pend_reg && !hold_v_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      mode_reg    <= MODE_OFF;
      rd_pend_reg <= 1'b0;
      hold_v_reg  <= 1'b0;
      hold_reg    <= '0;
      pat_reg     <= '0;
      di_reg      <= '0;
      wren_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_pend_reg <= RDEN;
      wren_reg    <= 1'b0;
      if (state_reg == IDLE && enable) begin
        mode_reg <= mode;
        if (mode == MODE_OFF) err_reg <= 1'b1;
      end
      // Held word has priority; it can never coincide with a fresh arrival.
      if (hold_v_reg) begin
        if (sink_ready) begin
          wren_reg   <= 1'b1;
          di_reg     <= hold_reg;
          hold_v_reg <= 1'b0;
        end
      end else if (rd_pend_reg) begin
        if (sink_ready) begin
          wren_reg <= 1'b1;
          di_reg   <= rx_word;
        end else begin
          hold_reg   <= rx_word;
          hold_v_reg <= 1'b1;
        end
      end else if (state_reg == RUN && mode_reg == MODE_CNT && sink_ready) begin
        wren_reg <= 1'b1;
        di_reg   <= pat_reg;
        pat_reg  <= pat_reg + PAT_ONE;
      end
    end
  end

  assign DI   = di_reg;
  assign WREN = wren_reg;
  assign busy = (state_reg != IDLE);
  assign err  = err_reg;

`ifdef LPGBT_EMU_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] word_cnt_reg;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      word_cnt_reg <= '0;
    end else if (wren_reg && (word_cnt_reg != {CNT_W{1'b1}})) begin
      word_cnt_reg <= word_cnt_reg + CNT_ONE;
    end
  end

  assign word_cnt = word_cnt_reg;
`else
  assign word_cnt = '0;
`endif

endmodule
